// File: rtl/led_pwm_pkg.sv
// Package for the memory-mapped PWM LED controller.
//
// Contents:
//   - word offsets of the 64-byte register window
//   - store-size codes carried on funct3
//   - ctrl_t: the CTRL register layout (bit 1 = invert, bit 0 = enable)
//   - store_t and merge_store(): byte/half/word lane merge of a store into
//     an existing 32-bit register image, flagging misaligned or unsupported
//     stores so the caller can drop them.

package led_pwm_pkg;

    // Word indices (byte offset >> 2) inside the register window.
    localparam logic [3:0] WORD_CTRL     = 4'd0;
    localparam logic [3:0] WORD_PRESCALE = 4'd1;
    localparam logic [3:0] WORD_STATUS   = 4'd2;
    localparam logic [3:0] WORD_FADE     = 4'd3;
    localparam int         DUTY_WORD0    = 4;

    // Only 12 duty words fit between offset 0x10 and the end of the window.
    localparam int         MAX_DUTY_REGS = 12;

    // Store sizes on funct3.
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic invert;
        logic enable;
    } ctrl_t;

    typedef struct packed {
        logic        ok;    // store is aligned and of a supported size
        logic [31:0] word;  // register image after the store
    } store_t;

    // Merge a right-justified store into the current register image.
    function automatic store_t merge_store(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        store_t r;
        r.ok   = 1'b0;
        r.word = old_word;
        case (f3)
            F3_SW: begin
                if (lane == 2'b00) begin
                    r.ok   = 1'b1;
                    r.word = wdata;
                end
            end
            F3_SH: begin
                if (!lane[0]) begin
                    r.ok = 1'b1;
                    r.word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                end
            end
            F3_SB: begin
                r.ok = 1'b1;
                r.word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: duty shadow register, optional fade stepper, compare and
// registered output.
//
// Optional feature macro: LED_PWM_FADE_EN (adds the i_fade port and a
// per-channel breathing stepper; absent by default).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_enable     global enable (CTRL.enable)
//   i_invert     global polarity (CTRL.invert)
//   i_wrap       last tick of the PWM period
//   i_fade       (LED_PWM_FADE_EN only) breathing enable for this channel
//   i_duty       pending duty, PWM_W+1 bits so full-on is representable
//   i_cnt        shared PWM counter
//   o_pwm        channel output, registered

module led_pwm_channel #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_invert,
    input  logic             i_wrap,
`ifdef LED_PWM_FADE_EN
    input  logic             i_fade,
`endif
    input  logic [PWM_W:0]   i_duty,
    input  logic [PWM_W-1:0] i_cnt,
    output logic             o_pwm
);

    logic [PWM_W:0] r_active;
    logic [PWM_W:0] w_active_next;
    logic           w_raw;

`ifdef LED_PWM_FADE_EN
    logic r_dir_up;
    logic w_dir_up_next;

    // While disabled a fading channel parks at 0 going up, so breathing
    // always starts from dark when the block is enabled.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_active_next = r_active;
        w_dir_up_next = r_dir_up;
        if (!i_enable) begin
            w_active_next = i_fade ? '0 : i_duty;
            w_dir_up_next = 1'b1;
        end else if (i_wrap) begin
            if (!i_fade) begin
                w_active_next = i_duty;
                w_dir_up_next = 1'b1;
            end else if (r_dir_up && (r_active < i_duty)) begin
                w_active_next = r_active + 1'b1;
                // Turn around in the same wrap that reaches the top.
                if (w_active_next == i_duty) begin
                    w_dir_up_next = 1'b0;
                end
            end else if (r_active != '0) begin
                w_active_next = r_active - 1'b1;
                w_dir_up_next = (w_active_next == '0);
            end else begin
                w_dir_up_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_up <= 1'b1;
        end else begin
            r_dir_up <= w_dir_up_next;
        end
    end
`else
    // Shadow copy: follows DUTY freely while disabled, otherwise only at the
    // period boundary so a pulse is never cut short or stretched.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_active_next = r_active;
        if (!i_enable || i_wrap) begin
            w_active_next = i_duty;
        end
    end
`endif

    // Duty of 2**PWM_W or more exceeds every counter value: always high.
    assign w_raw = ({1'b0, i_cnt} < r_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_active <= '0;
            o_pwm    <= 1'b0;
        end else begin
            r_active <= w_active_next;
            o_pwm    <= i_enable ? (w_raw ^ i_invert) : i_invert;
        end
    end

endmodule

// File: rtl/mmio_led_pwm.sv
// Memory-mapped NUM_CH-channel PWM LED controller on the core data bus.
//
// Optional feature macro: LED_PWM_FADE_EN (FADE register and per-channel
// breathing). Without it FADE reads 0 and ignores writes.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   write_mem       store strobe
//   funct3          store size (SB/SH/SW)
//   write_address   store byte address
//   write_data      store data, right-justified
//   read_address    load byte address
//   read_data       registered load data, 0 outside the window
//   read_hit        registered: previous read_address was in the window
//   pwm_out         channel outputs
//
// Register words: 0 CTRL, 1 PRESCALE, 2 STATUS (RO), 3 FADE, 4.. DUTY[i].

module mmio_led_pwm
    import led_pwm_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          PWM_W      = 8,
    parameter int          PRESCALE_W = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_mem,
    input  logic [2:0]        funct3,
    input  logic [31:0]       write_address,
    input  logic [31:0]       write_data,
    input  logic [31:0]       read_address,
    output logic [31:0]       read_data,
    output logic              read_hit,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int MAP_CH = (NUM_CH < MAX_DUTY_REGS) ? NUM_CH : MAX_DUTY_REGS;

    ctrl_t                         r_ctrl;
    logic [PRESCALE_W-1:0]         r_prescale;
    logic [NUM_CH-1:0][PWM_W:0]    r_duty;
`ifdef LED_PWM_FADE_EN
    logic [NUM_CH-1:0]             r_fade;
`endif
    logic [PRESCALE_W-1:0]         r_pre_cnt;
    logic [PWM_W-1:0]              r_cnt;

    logic [31:0] w_regs [16];
    logic        w_wr_hit;
    logic        w_rd_hit;
    logic [3:0]  w_wr_word;
    store_t      w_st;
    logic        w_we;
    logic        w_tick;
    logic        w_wrap;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Register image, shared by the read mux and the store lane merge.
    // ------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_regs[j] = '0;
        end
        w_regs[WORD_CTRL]                      = {30'd0, r_ctrl};
        w_regs[WORD_PRESCALE][PRESCALE_W-1:0]  = r_prescale;
        w_regs[WORD_STATUS][PWM_W-1:0]         = r_cnt;
        w_regs[WORD_STATUS][31]                = r_ctrl.enable;
`ifdef LED_PWM_FADE_EN
        w_regs[WORD_FADE][NUM_CH-1:0]          = r_fade;
`endif
        for (int i = 0; i < MAP_CH; i++) begin
            w_regs[DUTY_WORD0 + i][PWM_W:0] = r_duty[i];
        end
    end

    // ------------------------------------------------------------------
    // Store decode
    // ------------------------------------------------------------------
    assign w_wr_hit  = write_mem && (write_address[31:6] == BASE_ADDR[31:6]);
    assign w_wr_word = write_address[5:2];
    assign w_st      = merge_store(w_regs[w_wr_word], write_data, funct3,
                                   write_address[1:0]);
    assign w_we      = w_wr_hit && w_st.ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
`ifdef LED_PWM_FADE_EN
            r_fade     <= '0;
`endif
        end else if (w_we) begin
            case (w_wr_word)
                WORD_CTRL:     r_ctrl     <= ctrl_t'(w_st.word[1:0]);
                WORD_PRESCALE: r_prescale <= w_st.word[PRESCALE_W-1:0];
`ifdef LED_PWM_FADE_EN
                WORD_FADE:     r_fade     <= w_st.word[NUM_CH-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the duty bank is a few flops rather than a RAM, so it is
            // reset with everything else; no stale duty survives reset.
            r_duty <= '0;
        end else if (w_we) begin
            for (int i = 0; i < MAP_CH; i++) begin
                if (w_wr_word == 4'(DUTY_WORD0 + i)) begin
                    r_duty[i] <= w_st.word[PWM_W:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM counter. Both sit at 0 while disabled so the first
    // enabled period starts cleanly. A PRESCALE write below the running
    // count restarts the prescaler without a tick.
    // ------------------------------------------------------------------
    assign w_tick = r_ctrl.enable && (r_pre_cnt == r_prescale);
    assign w_wrap = w_tick && (r_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
        end else if (!r_ctrl.enable) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
        end else begin
            if (r_pre_cnt >= r_prescale) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_W    (PWM_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_enable (r_ctrl.enable),
            .i_invert (r_ctrl.invert),
            .i_wrap   (w_wrap),
`ifdef LED_PWM_FADE_EN
            .i_fade   (r_fade[g]),
`endif
            .i_duty   (r_duty[g]),
            .i_cnt    (r_cnt),
            .o_pwm    (pwm_out[g])
        );
    end

    // ------------------------------------------------------------------
    // Load path: full word, one cycle latency; the core picks the lane.
    // ------------------------------------------------------------------
    assign w_rd_hit = (read_address[31:6] == BASE_ADDR[31:6]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_hit  <= 1'b0;
            read_data <= '0;
        end else begin
            read_hit  <= w_rd_hit;
            read_data <= w_rd_hit ? w_regs[read_address[5:2]] : '0;
        end
    end

    // Byte lane of loads and the unused upper bits of store images.
    assign w_unused = ^{read_address[1:0], w_st.word};

endmodule
